// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
package aes_pkg;

    // Round counts for the three AES key sizes.
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Width of the round index; wide enough to hold 14.
    localparam int ROUND_W = 4;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round controller and its environment.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic               sel;
    logic               state_en;
    logic               key_load;
    logic               key_step;
    logic               last_round;
    logic [ROUND_W-1:0] round;
    logic               busy;

    // Controller side: consumes the handshakes, drives all datapath controls.
    modport master (
        input  in_valid, out_ready,
        output in_ready, out_valid, sel, state_en, key_load, key_step,
               last_round, round, busy
    );

    // Environment side: upstream/downstream plus the datapath being steered.
    modport slave (
        output in_valid, out_ready,
        input  in_ready, out_valid, sel, state_en, key_load, key_step,
               last_round, round, busy
    );

endinterface

// File: rtl/aes_round_counter.sv
// Round index counter: clears to 0, counts up one per inc, saturates at NR.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [ROUND_W-1:0] round,
    output logic               is_penult
);

    localparam logic [ROUND_W-1:0] LAST   = ROUND_W'(NR);
    localparam logic [ROUND_W-1:0] PENULT = ROUND_W'(NR - 1);

    logic [ROUND_W-1:0] round_q, round_d;

    // Next round index; clear wins over increment, and the count never passes NR.
    always_comb begin
        round_d = round_q;
        if (clr) begin
            round_d = '0;
        end else if (inc && (round_q != LAST)) begin
            round_d = round_q + 1'b1;
        end
    end

    // Round index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round     = round_q;
    assign is_penult = (round_q == PENULT);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: initial AddRoundKey, NR-1 full rounds, final round, hold result.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_ctrl_if.master  bus
);

    // Only the three standard AES round counts are meaningful.
    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
        $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end

    aes_state_e         state_q, state_d;
    logic               cnt_clr, cnt_inc, is_penult;
    logic [ROUND_W-1:0] round_w;

    aes_round_counter #(.NR(NR)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .round     (round_w),
        .is_penult (is_penult)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode; everything idles low unless a state raises it.
    always_comb begin
        state_d         = state_q;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.sel         = 1'b0;
        bus.state_en    = 1'b0;
        bus.key_load    = 1'b0;
        bus.key_step    = 1'b0;
        bus.last_round  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.key_load = 1'b1;
                    cnt_clr      = 1'b1;
                    state_d      = INIT;
                end
            end
            INIT: begin
                // Plaintext XOR key0 through the external mux leg.
                bus.state_en = 1'b1;
                bus.key_step = 1'b1;
                cnt_inc      = 1'b1;
                state_d      = ROUND;
            end
            ROUND: begin
                bus.sel      = 1'b1;
                bus.state_en = 1'b1;
                bus.key_step = 1'b1;
                cnt_inc      = 1'b1;
                if (is_penult) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                // Last key already in place, so the schedule does not advance.
                bus.sel        = 1'b1;
                bus.state_en   = 1'b1;
                bus.last_round = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.round = round_w;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed table, hand sequences and random traffic vs. a phase model.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_ctrl_if if10();
    aes_round_ctrl_if if14();

    aes_round_ctrl #(.NR(NR_128)) dut10 (.clk(clk), .rst(rst), .bus(if10.master));
    aes_round_ctrl #(.NR(NR_256)) dut14 (.clk(clk), .rst(rst), .bus(if14.master));

    // Observation word: {in_ready,out_valid,sel,state_en,key_load,key_step,last_round,busy,round[3:0]}
    logic [11:0] o10, o14;
    assign o10 = {if10.in_ready, if10.out_valid, if10.sel, if10.state_en, if10.key_load,
                  if10.key_step, if10.last_round, if10.busy, if10.round};
    assign o14 = {if14.in_ready, if14.out_valid, if14.sel, if14.state_en, if14.key_load,
                  if14.key_step, if14.last_round, if14.busy, if14.round};

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int age10  = -1;   // cycles since accept; -1 when idle
    int age14  = -1;
    int acc10[$];
    int first10, first14;
    int lr14_rnd;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        r;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [11:0] mk(logic ir, logic ov, logic sl, logic en, logic kl,
                                       logic ks, logic lr, logic bz, int rnd);
        return {ir, ov, sl, en, kl, ks, lr, bz, 4'(rnd)};
    endfunction

    // Reference: outputs are a function of how many cycles ago the block was accepted.
    function automatic logic [11:0] model(int age, int nr, logic iv);
        if (age < 0)            return mk(1, 0, 0, 0, iv, 0, 0, 0, 0);
        else if (age == 1)      return mk(0, 0, 0, 1, 0, 1, 0, 1, 0);
        else if (age <= nr)     return mk(0, 0, 1, 1, 0, 1, 0, 1, age - 1);
        else if (age == nr + 1) return mk(0, 0, 1, 1, 0, 0, 1, 1, nr);
        else                    return mk(0, 1, 0, 0, 0, 0, 0, 1, nr);
    endfunction

    function automatic int next_age(int age, int nr, logic r, logic iv, logic ordy);
        if (r)              return -1;
        if (age < 0)        return iv ? 1 : -1;
        if (age >= nr + 2)  return ordy ? -1 : age;
        return age + 1;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %03h expected %03h", name, cyc_n, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic tick(input logic iv, input logic ordy, input logic r, input logic chk,
                        input logic use_t, input logic [11:0] texp, input string tname);
        if10.in_valid = iv;  if14.in_valid = iv;
        if10.out_ready = ordy; if14.out_ready = ordy;
        rst = r;
        @(negedge clk);
        if (chk) begin
            check("model10", o10, model(age10, NR_128, iv));
            check("model14", o14, model(age14, NR_256, iv));
        end
        if (use_t) check(tname, o10, texp);
        if (if10.in_ready === 1'b1 && iv && !r) acc10.push_back(cyc_n);
        if (if10.out_valid === 1'b1 && first10 < 0) first10 = cyc_n;
        if (if14.out_valid === 1'b1 && first14 < 0) first14 = cyc_n;
        if (if14.last_round === 1'b1) lr14_rnd = int'(if14.round);
        @(posedge clk);
        age10 = next_age(age10, NR_128, r, iv, ordy);
        age14 = next_age(age14, NR_256, r, iv, ordy);
        cyc_n++;
        #1;
    endtask

    task automatic t0(input logic iv, input logic ordy, input logic r);
        tick(iv, ordy, r, 1'b1, 1'b0, 12'h0, "");
    endtask

    initial begin
        int t_acc;
        logic [11:0] idle_w, done10_w;
        idle_w   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        done10_w = mk(0, 1, 0, 0, 0, 0, 0, 1, 10);
        first10 = -1; first14 = -1; lr14_rnd = -1;

        // Directed single block for NR=10 with out_ready high.
        tbl.push_back('{1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 1, 0, 1, 0, 1, 0)});
        for (int k = 1; k <= 9; k++)
            tbl.push_back('{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 1, 0, 1, k)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 1, 1, 10)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, done10_w});
        tbl.push_back('{1'b0, 1'b1, 1'b0, idle_w});

        // Reset, then 20 quiet idle cycles.
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, "");
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, "");
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, idle_w, "idle");

        for (int i = 0; i < tbl.size(); i++)
            tick(tbl[i].iv, tbl[i].ordy, tbl[i].r, 1'b1, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        for (int i = 0; i < 6; i++) t0(1'b0, 1'b1, 1'b0);   // let NR=14 drain

        // Backpressure: hold out_ready low for 7 cycles of out_valid, with in_valid pulses.
        first10 = -1;
        t0(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && first10 < 0; i++) t0(1'b0, 1'b0, 1'b0);
        checki("bp_reach_done", (first10 >= 0) ? 1 : 0, 1);
        for (int i = 0; i < 7; i++)
            tick(i[0], 1'b0, 1'b0, 1'b1, 1'b1, done10_w, "bp_hold");
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, done10_w, "bp_release");
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, idle_w, "bp_idle");
        for (int i = 0; i < 20; i++) t0(1'b0, 1'b1, 1'b0);

        // Back-to-back accepts with in_valid and out_ready held high.
        acc10.delete();
        for (int i = 0; i < 3 * 13 + 2; i++) t0(1'b1, 1'b1, 1'b0);
        checki("b2b_count", (acc10.size() >= 3) ? 1 : 0, 1);
        if (acc10.size() >= 3) begin
            checki("b2b_gap1", acc10[1] - acc10[0], 13);
            checki("b2b_gap2", acc10[2] - acc10[1], 13);
        end
        for (int i = 0; i < 20; i++) t0(1'b0, 1'b1, 1'b0);

        // Reset at round 5, then a fresh block with normal latency.
        t0(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && if10.round != 4'd5; i++) t0(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 1, 1, 0, 1, 0, 1, 5), "rst_at_r5");
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, idle_w, "after_rst");
        first10 = -1; first14 = -1; lr14_rnd = -1;
        t_acc = cyc_n;
        t0(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && first14 < 0; i++) t0(1'b0, 1'b1, 1'b0);
        checki("lat10", first10 - t_acc, 12);
        checki("lat14", first14 - t_acc, 16);
        checki("lr14_round", lr14_rnd, 14);
        for (int i = 0; i < 4; i++) t0(1'b0, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            t0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 99) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
